// File: rtl/taxi_axis_if.sv
// taxi_axis_if: AXI4-Stream bundle shared by the taxi stream blocks.
//
// Parameters size the payload. Optional sidebands are selected with the *_EN
// flags. The wires always exist, so consumers can tie off or ignore them.
//
// Signals: tdata, tkeep, tstrb, tvalid, tready, tlast, tid, tdest, tuser.
// Modports:
//   src - drives the stream (all payload plus tvalid; samples tready).
//   snk - receives the stream (samples payload plus tvalid; drives tready).
interface taxi_axis_if #(
  parameter int DATA_W  = 8,
  parameter bit KEEP_EN = (DATA_W > 8),
  parameter int KEEP_W  = ((DATA_W + 7) / 8),
  parameter bit STRB_EN = 1'b0,
  parameter bit LAST_EN = 1'b1,
  parameter bit ID_EN   = 1'b0,
  parameter int ID_W    = 8,
  parameter bit DEST_EN = 1'b0,
  parameter int DEST_W  = 8,
  parameter bit USER_EN = 1'b0,
  parameter int USER_W  = 1
) ();
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [KEEP_W-1:0] tstrb;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;

  modport src (
    output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
    input  tready
  );

  modport snk (
    input  tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/taxi_axis_frame_serializer.sv
// taxi_axis_frame_serializer: narrowing AXI4-Stream serializer.
//
// The block accepts one wide beat into a holding register. It then emits the
// beat as RATIO = S_KEEP_W/M_KEEP_W narrow segments, lowest lanes first.
// With SKIP_EMPTY set, segments whose keep is all zero are skipped. Frames
// therefore leave compacted at segment granularity. tid/tdest/tuser are held
// for the whole beat.
//
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   s_axis       - wide input stream (taxi_axis_if.snk)
//   m_axis       - narrow output stream (taxi_axis_if.src)
//   status_busy  - holding register occupied
//   status_seg   - index of the segment currently presented
//   stat_frames  - (TAXI_AXIS_SER_STATS_EN only) count of tlast handshakes
//   stat_segs    - (TAXI_AXIS_SER_STATS_EN only) count of output handshakes
//
// Parameters:
//   SEG_W must equal $clog2(RATIO), with a minimum of 1.
//
// Build option:
//   Define TAXI_AXIS_SER_STATS_EN to add the two 32-bit wrapping counters.
module taxi_axis_frame_serializer #(
  parameter logic SKIP_EMPTY     = 1'b1,
  parameter logic USER_LAST_ONLY = 1'b0,
  parameter int   SEG_W          = 2
) (
  input  logic             clk,
  input  logic             rst,
  taxi_axis_if.snk         s_axis,
  taxi_axis_if.src         m_axis,
  output logic             status_busy,
  output logic [SEG_W-1:0] status_seg
`ifdef TAXI_AXIS_SER_STATS_EN
  ,
  output logic [31:0]      stat_frames,
  output logic [31:0]      stat_segs
`endif
);

  localparam int S_DATA_W  = s_axis.DATA_W;
  localparam int S_KEEP_W  = s_axis.KEEP_W;
  localparam bit S_KEEP_EN = s_axis.KEEP_EN;
  localparam bit S_STRB_EN = s_axis.STRB_EN;
  localparam bit S_LAST_EN = s_axis.LAST_EN;
  localparam int M_DATA_W  = m_axis.DATA_W;
  localparam int M_KEEP_W  = m_axis.KEEP_W;
  localparam bit M_KEEP_EN = m_axis.KEEP_EN;
  localparam bit M_STRB_EN = m_axis.STRB_EN;
  localparam bit M_LAST_EN = m_axis.LAST_EN;
  localparam bit M_ID_EN   = m_axis.ID_EN;
  localparam int M_ID_W    = m_axis.ID_W;
  localparam bit M_DEST_EN = m_axis.DEST_EN;
  localparam int M_DEST_W  = m_axis.DEST_W;
  localparam bit M_USER_EN = m_axis.USER_EN;
  localparam int M_USER_W  = m_axis.USER_W;

  localparam int S_BYTE_SIZE = S_DATA_W / S_KEEP_W;
  localparam int M_BYTE_SIZE = M_DATA_W / M_KEEP_W;
  localparam int RATIO       = S_KEEP_W / M_KEEP_W;
  localparam int SEG_W_CALC  = (RATIO > 2) ? $clog2(RATIO) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  if (S_BYTE_SIZE != M_BYTE_SIZE) begin : g_bad_byte
    $fatal(1, "byte size mismatch between s_axis and m_axis");
  end
  if (((S_KEEP_W % M_KEEP_W) != 0) || (RATIO < 2)) begin : g_bad_ratio
    $fatal(1, "S_KEEP_W must be an integer multiple (>=2) of M_KEEP_W");
  end
  if (!M_KEEP_EN && SKIP_EMPTY) begin : g_bad_keep
    $fatal(1, "SKIP_EMPTY requires tkeep on m_axis");
  end
  if (SEG_W != SEG_W_CALC) begin : g_bad_segw
    $fatal(1, "SEG_W does not match the segment count");
  end

  // A segment carries data when any of its keep lanes is set.
  function automatic logic seg_has_data(input logic [S_KEEP_W-1:0] keep, input int idx);
    return |keep[idx*M_KEEP_W +: M_KEEP_W];
  endfunction

  logic [0:0]          state_q, state_d;
  logic [SEG_W-1:0]    seg_idx_q, seg_idx_d;
  logic [S_DATA_W-1:0] data_q, data_d;
  logic [S_KEEP_W-1:0] keep_q, keep_d;
  logic [S_KEEP_W-1:0] strb_q, strb_d;
  logic                last_q, last_d;
  logic [M_ID_W-1:0]   id_q, id_d;
  logic [M_DEST_W-1:0] dest_q, dest_d;
  logic [M_USER_W-1:0] user_q, user_d;

  logic                hold_valid;
  logic                s_ready, s_hs, m_hs, m_last;
  logic [S_KEEP_W-1:0] s_keep, s_strb;
  logic                s_last, s_any;
  logic [SEG_W-1:0]    first_seg, next_seg;
  logic                seg_cand, more_seg, last_seg;
  logic [M_DATA_W-1:0] seg_data;
  logic [M_KEEP_W-1:0] seg_keep, seg_strb;

  assign hold_valid = (state_q == ST_SEND);

  // Normalise the input sidebands. An absent keep means every lane is valid.
  always_comb begin
    s_keep = S_KEEP_EN ? s_axis.tkeep : {S_KEEP_W{1'b1}};
    s_strb = S_STRB_EN ? s_axis.tstrb : s_keep;
    s_last = S_LAST_EN ? s_axis.tlast : 1'b1;
  end

  // Find the first segment to present for the incoming beat.
  // Scanning downward leaves the lowest nonempty segment in first_seg.
  always_comb begin
    first_seg = {SEG_W{1'b0}};
    s_any     = 1'b0;
    for (int i = RATIO - 1; i >= 0; i--) begin
      first_seg = seg_has_data(s_keep, i) ? SEG_W'(i) : first_seg;
      s_any     = s_any | seg_has_data(s_keep, i);
    end
    first_seg = SKIP_EMPTY ? first_seg : {SEG_W{1'b0}};
  end

  // Find the next segment after seg_idx. If none remains, this segment is the last one.
  always_comb begin
    next_seg = seg_idx_q;
    more_seg = 1'b0;
    seg_cand = 1'b0;
    for (int i = RATIO - 1; i >= 0; i--) begin
      seg_cand = (i > int'(seg_idx_q)) && (!SKIP_EMPTY || seg_has_data(keep_q, i));
      next_seg = seg_cand ? SEG_W'(i) : next_seg;
      more_seg = more_seg | seg_cand;
    end
    last_seg = !more_seg;
  end

  // Select the lanes of the presented segment from the holding register.
  always_comb begin
    seg_data = {M_DATA_W{1'b0}};
    seg_keep = {M_KEEP_W{1'b0}};
    seg_strb = {M_KEEP_W{1'b0}};
    for (int i = 0; i < RATIO; i++) begin
      seg_data = (seg_idx_q == SEG_W'(i)) ? data_q[i*M_DATA_W +: M_DATA_W] : seg_data;
      seg_keep = (seg_idx_q == SEG_W'(i)) ? keep_q[i*M_KEEP_W +: M_KEEP_W] : seg_keep;
      seg_strb = (seg_idx_q == SEG_W'(i)) ? strb_q[i*M_KEEP_W +: M_KEEP_W] : seg_strb;
    end
  end

  // Handshakes. A new beat may load on the same edge the last segment leaves.
  always_comb begin
    m_hs    = hold_valid && m_axis.tready && !rst;
    s_ready = !rst && (!hold_valid || (m_axis.tready && last_seg));
    s_hs    = s_axis.tvalid && s_ready;
    m_last  = last_q && last_seg;
  end

  // Next-state logic for the holding register and the segment pointer.
  always_comb begin
    state_d   = state_q;
    seg_idx_d = seg_idx_q;
    data_d    = data_q;
    keep_d    = keep_q;
    strb_d    = strb_q;
    last_d    = last_q;
    id_d      = id_q;
    dest_d    = dest_q;
    user_d    = user_q;
    if (s_hs) begin
      data_d    = s_axis.tdata;
      keep_d    = s_keep;
      strb_d    = s_strb;
      last_d    = s_last;
      id_d      = M_ID_W'(s_axis.tid);
      dest_d    = M_DEST_W'(s_axis.tdest);
      user_d    = M_USER_W'(s_axis.tuser);
      seg_idx_d = first_seg;
      // An all-empty beat without tlast carries nothing and is dropped here.
      // An all-empty beat with tlast still emits segment 0 to close the frame.
      state_d   = (s_any || s_last || !SKIP_EMPTY) ? ST_SEND : ST_IDLE;
    end else if (m_hs) begin
      state_d   = last_seg ? ST_IDLE : ST_SEND;
      seg_idx_d = last_seg ? {SEG_W{1'b0}} : next_seg;
    end else begin
      state_d   = state_q;
      seg_idx_d = seg_idx_q;
    end
  end

  // Control state with synchronous reset; a reset mid-beat drops the remaining segments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      seg_idx_q <= {SEG_W{1'b0}};
    end else begin
      state_q   <= state_d;
      seg_idx_q <= seg_idx_d;
    end
  end

  // Holding-register payload; it is qualified by state_q, so it needs no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    keep_q <= keep_d;
    strb_q <= strb_d;
    last_q <= last_d;
    id_q   <= id_d;
    dest_q <= dest_d;
    user_q <= user_d;
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = hold_valid && !rst;
  assign m_axis.tdata  = seg_data;
  assign m_axis.tkeep  = seg_keep;
  assign m_axis.tstrb  = M_STRB_EN ? seg_strb : seg_keep;
  assign m_axis.tlast  = M_LAST_EN ? m_last : 1'b0;
  assign m_axis.tid    = M_ID_EN ? id_q : {M_ID_W{1'b0}};
  assign m_axis.tdest  = M_DEST_EN ? dest_q : {M_DEST_W{1'b0}};
  assign m_axis.tuser  = (M_USER_EN && (!USER_LAST_ONLY || m_last)) ? user_q : {M_USER_W{1'b0}};
  assign status_busy   = hold_valid;
  assign status_seg    = seg_idx_q;

`ifdef TAXI_AXIS_SER_STATS_EN
  logic [31:0] stat_frames_q, stat_frames_d;
  logic [31:0] stat_segs_q, stat_segs_d;

  // Handshake counters; they wrap naturally at 2^32.
  always_comb begin
    stat_frames_d = stat_frames_q + ((m_hs && M_LAST_EN && m_last) ? 32'd1 : 32'd0);
    stat_segs_d   = stat_segs_q + (m_hs ? 32'd1 : 32'd0);
  end

  // Counter registers cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames_q <= 32'd0;
      stat_segs_q   <= 32'd0;
    end else begin
      stat_frames_q <= stat_frames_d;
      stat_segs_q   <= stat_segs_d;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_segs   = stat_segs_q;
`endif

endmodule

// File: tb/tb_taxi_axis_frame_serializer.sv
// Testbench for taxi_axis_frame_serializer. It uses a 64-bit input stream and
// a 16-bit output stream, so RATIO = 4. SKIP_EMPTY is set to 1.
module tb_taxi_axis_frame_serializer;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [7:0]  strb;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [1:0]  user;
  } beat_t;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic [1:0]  strb;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [1:0]  user;
  } seg_t;

  logic       clk;
  logic       rst;
  logic       status_busy;
  logic [1:0] status_seg;
`ifdef TAXI_AXIS_SER_STATS_EN
  logic [31:0] stat_frames;
  logic [31:0] stat_segs;
`endif

  taxi_axis_if #(.DATA_W(64), .KEEP_EN(1'b1), .KEEP_W(8), .STRB_EN(1'b1), .LAST_EN(1'b1),
                 .ID_EN(1'b1), .ID_W(4), .DEST_EN(1'b1), .DEST_W(4), .USER_EN(1'b1), .USER_W(2)) s_if ();
  taxi_axis_if #(.DATA_W(16), .KEEP_EN(1'b1), .KEEP_W(2), .STRB_EN(1'b1), .LAST_EN(1'b1),
                 .ID_EN(1'b1), .ID_W(4), .DEST_EN(1'b1), .DEST_W(4), .USER_EN(1'b1), .USER_W(2)) m_if ();

  taxi_axis_frame_serializer #(
    .SKIP_EMPTY(1'b1),
    .USER_LAST_ONLY(1'b0),
    .SEG_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis(s_if),
    .m_axis(m_if),
    .status_busy(status_busy),
    .status_seg(status_seg)
`ifdef TAXI_AXIS_SER_STATS_EN
    ,
    .stat_frames(stat_frames),
    .stat_segs(stat_segs)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors;
  int checks;
  beat_t in_q[$];
  seg_t  exp_q[$];
  seg_t  obs_q[$];
  int    idx_q[$];
  int    stall_viol, valid_cycles, first_v, last_v;
  bit    rdy_at_last, timed_out;
  localparam logic [63:0] PAT = 64'h8877_6655_4433_2211;

  // Reference: split the beat into segments, keep the nonempty ones, and put
  // tlast on the final one. An empty beat with tlast gives one empty segment.
  function automatic void model_beat(input beat_t b);
    seg_t s;
    int   n = 0;
    for (int i = 0; i < 4; i++) begin
      if (b.keep[2*i +: 2] != 2'b00) begin
        s.data = b.data[16*i +: 16];
        s.keep = b.keep[2*i +: 2];
        s.strb = b.strb[2*i +: 2];
        s.last = 1'b0;
        s.id = b.id; s.dest = b.dest; s.user = b.user;
        exp_q.push_back(s);
        n++;
      end
    end
    if (n > 0) exp_q[$].last = b.last;
    else if (b.last) begin
      s.data = b.data[15:0]; s.keep = 2'b00; s.strb = b.strb[1:0]; s.last = 1'b1;
      s.id = b.id; s.dest = b.dest; s.user = b.user;
      exp_q.push_back(s);
    end
  endfunction

  task automatic add_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    beat_t b;
    b.data = d; b.keep = k; b.strb = k & 8'($urandom); b.last = l;
    b.id = 4'($urandom); b.dest = 4'($urandom); b.user = 2'($urandom);
    in_q.push_back(b);
    model_beat(b);
  endtask

  // Drive queued beats and collect the output handshakes. The tests do the comparing.
  task automatic run_stream(input int vld_pct, input int rdy_pct, input int max_cycles);
    int   cyc = 0;
    seg_t cur, prev;
    bit   stall_prev = 1'b0;
    prev = '0;
    obs_q.delete(); idx_q.delete();
    stall_viol = 0; valid_cycles = 0; first_v = -1; last_v = -1;
    rdy_at_last = 1'b0; timed_out = 1'b0;
    forever begin
      @(negedge clk);
      if (in_q.size() == 0 && !status_busy) break;
      if (cyc >= max_cycles) begin timed_out = 1'b1; break; end
      if (in_q.size() > 0 && ($urandom_range(99) < 32'(vld_pct))) begin
        s_if.tdata = in_q[0].data; s_if.tkeep = in_q[0].keep; s_if.tstrb = in_q[0].strb;
        s_if.tlast = in_q[0].last; s_if.tid = in_q[0].id; s_if.tdest = in_q[0].dest;
        s_if.tuser = in_q[0].user; s_if.tvalid = 1'b1;
      end else s_if.tvalid = 1'b0;
      m_if.tready = ($urandom_range(99) < 32'(rdy_pct));
      #1;
      cur.data = m_if.tdata; cur.keep = m_if.tkeep; cur.strb = m_if.tstrb; cur.last = m_if.tlast;
      cur.id = m_if.tid; cur.dest = m_if.tdest; cur.user = m_if.tuser;
      if (m_if.tvalid) begin
        valid_cycles++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (stall_prev && (!m_if.tvalid || cur !== prev)) stall_viol++;
      stall_prev = m_if.tvalid && !m_if.tready;
      prev = cur;
      if (m_if.tvalid && m_if.tready) begin
        obs_q.push_back(cur);
        idx_q.push_back(int'(status_seg));
        if (m_if.tlast) rdy_at_last = s_if.tready;
      end
      if (s_if.tvalid && s_if.tready) void'(in_q.pop_front());
      cyc++;
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", m_if.tvalid); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", s_if.tready); end
    checks++; if (status_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", status_busy); end
    checks++; if (status_seg !== 2'd0) begin errors++; $display("FAIL rst_seg: got %0d want 0", status_seg); end
`ifdef TAXI_AXIS_SER_STATS_EN
    checks++; if (stat_frames !== 32'd0 || stat_segs !== 32'd0) begin errors++; $display("FAIL rst_stats: got %0d/%0d want 0/0", stat_frames, stat_segs); end
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL rst_release_tready: got %b want 1", s_if.tready); end
  endtask

  task automatic test_full();
    in_q.delete(); exp_q.delete();
    add_beat(PAT, 8'hFF, 1'b1);
    run_stream(100, 100, 50);
    checks++; if (timed_out) begin errors++; $display("FAIL full_timeout: got 1 want 0"); end
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL full_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_seg%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
      checks++; if (idx_q[i] != i) begin errors++; $display("FAIL full_idx%0d: got %0d want %0d", i, idx_q[i], i); end
    end
    checks++; if (first_v != 1) begin errors++; $display("FAIL full_latency: got %0d want 1", first_v); end
    checks++; if (valid_cycles != 4) begin errors++; $display("FAIL full_cycles: got %0d want 4", valid_cycles); end
    checks++; if (rdy_at_last !== 1'b1) begin errors++; $display("FAIL full_tready_last: got %b want 1", rdy_at_last); end
  endtask

  task automatic test_partial();
    int exp_idx[6] = '{0, 1, 0, 1, 0, 3};
    in_q.delete(); exp_q.delete();
    add_beat(PAT, 8'h0F, 1'b1);
    add_beat(PAT, 8'h07, 1'b1);
    add_beat(PAT, 8'hC3, 1'b1);
    run_stream(100, 100, 100);
    checks++; if (timed_out) begin errors++; $display("FAIL partial_timeout: got 1 want 0"); end
    checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL partial_count: got %0d want 6", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL partial_seg%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
      checks++; if (idx_q[i] != exp_idx[i]) begin errors++; $display("FAIL partial_idx%0d: got %0d want %0d", i, idx_q[i], exp_idx[i]); end
    end
  endtask

  task automatic test_empty();
    in_q.delete(); exp_q.delete();
    add_beat(PAT, 8'h00, 1'b1);
    run_stream(100, 100, 50);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL empty_last_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL empty_last_seg: got %h want %h", obs_q[0], exp_q[0]); end
    end
    in_q.delete(); exp_q.delete();
    add_beat(PAT, 8'h00, 1'b0);
    run_stream(100, 100, 50);
    #1;
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL empty_nolast_count: got %0d want 0", obs_q.size()); end
    checks++; if (s_if.tready !== 1'b1 || status_busy !== 1'b0) begin errors++; $display("FAIL empty_nolast_ready: got tready=%b busy=%b want 1/0", s_if.tready, status_busy); end
  endtask

  task automatic test_back_to_back();
    in_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) add_beat({$urandom, $urandom}, 8'hFF, 1'b1);
    run_stream(100, 100, 100);
    checks++; if (valid_cycles != 12) begin errors++; $display("FAIL b2b_valid: got %0d want 12", valid_cycles); end
    checks++; if (last_v - first_v != 11) begin errors++; $display("FAIL b2b_span: got %0d want 11", last_v - first_v); end
    checks++; if (obs_q.size() != 12) begin errors++; $display("FAIL b2b_count: got %0d want 12", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_seg%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    in_q.delete(); exp_q.delete();
    for (int i = 0; i < 40; i++)
      add_beat({$urandom, $urandom}, ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom), 1'($urandom_range(1)));
    run_stream(70, 50, 2000);
    checks++; if (timed_out) begin errors++; $display("FAIL rand_timeout: got 1 want 0"); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_seg%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL rand_stable: got %0d changes want 0", stall_viol); end
  endtask

  task automatic test_reset_mid();
    bit tl_seen = 1'b0;
    @(negedge clk);
    s_if.tdata = PAT; s_if.tkeep = 8'hFF; s_if.tstrb = 8'hFF; s_if.tlast = 1'b1;
    s_if.tvalid = 1'b1; m_if.tready = 1'b1;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    repeat (2) begin
      #1;
      if (m_if.tvalid && m_if.tready && m_if.tlast) tl_seen = 1'b1;
      @(negedge clk);
    end
    #1;
    checks++; if (status_busy !== 1'b1 || status_seg !== 2'd2) begin errors++; $display("FAIL mid_pre: got busy=%b seg=%0d want 1/2", status_busy, status_seg); end
    rst = 1'b1;
    @(negedge clk);
    #1;
    if (m_if.tvalid && m_if.tlast) tl_seen = 1'b1;
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %b want 0", m_if.tvalid); end
    checks++; if (status_busy !== 1'b0 || status_seg !== 2'd0) begin errors++; $display("FAIL mid_status: got busy=%b seg=%0d want 0/0", status_busy, status_seg); end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      if (m_if.tvalid && m_if.tlast) tl_seen = 1'b1;
    end
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL mid_after_tvalid: got %b want 0", m_if.tvalid); end
    checks++; if (tl_seen) begin errors++; $display("FAIL mid_tlast: got 1 want 0"); end
`ifdef TAXI_AXIS_SER_STATS_EN
    checks++; if (stat_frames !== 32'd0 || stat_segs !== 32'd0) begin errors++; $display("FAIL mid_stats_clear: got %0d/%0d want 0/0", stat_frames, stat_segs); end
    in_q.delete(); exp_q.delete();
    add_beat(PAT, 8'hFF, 1'b1);
    run_stream(100, 100, 50);
    #1;
    checks++; if (stat_frames !== 32'd1 || stat_segs !== 32'd4) begin errors++; $display("FAIL mid_stats_count: got %0d/%0d want 1/4", stat_frames, stat_segs); end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tstrb = '0;
    s_if.tlast = 1'b0; s_if.tid = '0; s_if.tdest = '0; s_if.tuser = '0;
    m_if.tready = 1'b0;
    test_reset();
    test_full();
    test_partial();
    test_empty();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/taxi_axis_frame_serializer.md
Name: taxi_axis_frame_serializer

Overview:
- Narrowing AXI4-Stream serializer: accepts one wide beat and emits it as RATIO = S_KEEP_W/M_KEEP_W narrow segments, lowest lanes first.
- Segments whose keep is all-zero are skipped, so frames leave byte-compacted at segment granularity.
- Sits on the read side of wide frame FIFOs, feeding narrow MAC/PHY-side or CSR-side consumers.
- Sideband (tid/tdest/tuser) is held for the whole beat.

Parameters:
- SKIP_EMPTY, 1'b1, drop segments with all-zero tkeep (except the rules below).
- USER_LAST_ONLY, 1'b0, drive m_axis.tuser only on the tlast segment; 0 elsewhere.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- s_axis  taxi_axis_if.snk  S_DATA_W (interface)  wide input stream
- m_axis  taxi_axis_if.src  M_DATA_W (interface)  narrow output stream
- status_busy  output  1  holding register occupied
- status_seg  output  $clog2(RATIO) (min 1)  index of the segment currently presented

Behaviour:
- Config checks:
  - $fatal if S_BYTE_SIZE != M_BYTE_SIZE.
  - $fatal if S_KEEP_W is not an integer multiple (>=2) of M_KEEP_W.
  - $fatal if M_KEEP_EN=0 while SKIP_EMPTY=1.
- Storage: one holding register (data, keep, strb, last, id, dest, user), hold_valid flag, seg_idx counter.
- State machine:
  - IDLE: hold_valid=0; s_axis.tready=1.
  - On accept, load the beat, compute first_seg = lowest segment index with nonzero keep, and go to SEND.
  - SEND: m_axis.tvalid=1; m_axis.tdata/tkeep/tstrb = segment seg_idx.
  - On m_axis handshake, seg_idx advances to the next segment with nonzero keep.
  - If none remains, the current segment is last_seg.
- Last-segment handling:
  - m_axis.tlast = held tlast AND last_seg.
  - If held tlast=1 and all keep=0: emit one segment 0, keep=0, tlast=1.
  - If held tlast=0 and all keep=0: consume the beat silently, no output.
- Throughput: s_axis.tready = !hold_valid || (m_axis.tready && last_seg). Back-to-back beats therefore run with no bubble; a new beat loads on the same edge the last segment leaves.
- Latency: first segment valid on the cycle after input acceptance; a full beat takes N cycles, where N = number of nonempty segments.
- Sideband: tid/tdest/tuser constant across all segments of a beat (tuser per USER_LAST_ONLY).
- SKIP_EMPTY=0: all RATIO segments are emitted regardless of keep.
- Backpressure: m_axis outputs must stay stable while tvalid=1 and tready=0.
- Reset:
  - m_axis.tvalid=0, s_axis.tready=0 while rst=1.
  - hold_valid=0, seg_idx=0, status_busy=0, status_seg=0.
  - s_axis.tready rises the cycle rst deasserts.
- Reset mid-beat: remaining segments are discarded; no partial tlast is generated.
- Status: status_busy = hold_valid; status_seg = seg_idx.

Optional Feature:
- Macro: TAXI_AXIS_SER_STATS_EN.
- Defined:
  - Adds outputs stat_frames [31:0] and stat_segs [31:0].
  - stat_frames increments on each m_axis handshake with tlast=1.
  - stat_segs increments on every m_axis handshake.
  - Both wrap at 2^32 and clear on rst.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan (all cases: S_DATA_W=64, 8 lanes, M_DATA_W=16, 2 lanes, RATIO=4, SKIP_EMPTY=1):
1. Beat 0x8877_6655_4433_2211, keep 0xFF, tlast=1, m_axis.tready=1 -> 4 segments 0x2211, 0x4433, 0x6655, 0x8877; keep 0x3 each; tlast only on 4th; s_axis.tready back high in cycle 4.
2. Keep 0x0F, tlast=1 -> 2 segments 0x2211, 0x4433; 2nd has tlast=1; segments 2-3 skipped.
3. Keep 0x07, tlast=1 -> segment 0x2211 keep 0x3, then 0x4433 keep 0x1 with tlast=1.
4. Keep 0x00, tlast=1 -> single segment keep 0x0, tlast=1. Keep 0x00, tlast=0 -> no output, tready high next cycle.
5. Three full beats back-to-back, tready=1 -> 12 contiguous valid cycles, no bubble. Random tready 50% -> data identical and stable while stalled.
6. Assert rst after 2nd segment of a beat -> tvalid=0 next cycle, no tlast emitted, status_busy=0. With TAXI_AXIS_SER_STATS_EN: stat_frames=0, stat_segs=0 after reset; test 1 repeated gives stat_frames=1, stat_segs=4.
